// File: rtl/serial_link_pkg.sv
// Shared types for the serial link controller: opcodes, FSM states, opcode width.
package serial_link_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 2'b00,
        OP_READ = 2'b01,
        OP_RUN  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_RUN   = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

endpackage

// File: rtl/serial_link_shifter.sv
// Frame shift register: parallel load, MSB-first shift-out, LSB shift-in.
module serial_link_shifter
    import serial_link_pkg::*;
#(
    parameter int data_size = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [data_size-1:0] load_val,
    input  logic                 shift_en,
    input  logic                 shift_in,
    output logic [data_size-1:0] q
);

    logic [data_size-1:0] shift_d;
    logic [data_size-1:0] shift_q;

    // Next-value selection: load has priority over shift.
    always_comb begin
        shift_d = shift_q;
        if (load_en) begin
            shift_d = load_val;
        end else if (shift_en) begin
            shift_d = {shift_q[data_size-2:0], shift_in};
        end else begin
            shift_d = shift_q;
        end
    end

    // Shift register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= {data_size{1'b0}};
        end else begin
            shift_q <= shift_d;
        end
    end

    assign q = shift_q;

endmodule

// File: rtl/serial_link_ctrl.sv
// Host-side serial memory controller: LOAD/READ/RUN command sequencing.
// Optional RUN command is compiled in with `define SERIAL_LINK_CTRL_RUN_EN.
module serial_link_ctrl
    import serial_link_pkg::*;
#(
    parameter int data_size = 64,
    parameter int gen_width = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic [OP_W-1:0]      CMD_OP,
    input  logic [data_size-1:0] CMD_DATA,
    input  logic [gen_width-1:0] CMD_GENS,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic [data_size-1:0] RSP_DATA,
    output logic                 RSP_ERR,
    output logic                 LOAD_MODE,
    output logic                 OUTPUT_MODE,
    output logic                 RUN_MODE,
    output logic                 SERIAL_IN,
    input  logic                 MEM_SERIAL_OUT
);

    localparam int CNT_W = $clog2(data_size + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(data_size);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e               state_d, state_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;
    logic                 load_mode_d, load_mode_q;
    logic                 output_mode_d, output_mode_q;
    logic                 serial_in_d, serial_in_q;
    logic                 cmd_ready_d, cmd_ready_q;
    logic                 rsp_valid_d, rsp_valid_q;
    logic                 rsp_err_d, rsp_err_q;
    logic [data_size-1:0] rsp_data_d, rsp_data_q;
    logic                 sh_load_s, sh_shift_s;
    logic [data_size-1:0] sh_q_s;
    op_e                  op_s;
`ifdef SERIAL_LINK_CTRL_RUN_EN
    logic [gen_width-1:0] gen_d, gen_q;
    logic                 run_mode_d, run_mode_q;
`else
    logic                 unused_gens_s;
`endif

    assign op_s = op_e'(CMD_OP);

    // Preloaded pre-shifted by one: the MSB goes straight to SERIAL_IN on accept.
    serial_link_shifter #(.data_size(data_size)) u_shifter (
        .clk      (CLK),
        .rst      (RESET),
        .load_en  (sh_load_s),
        .load_val ({CMD_DATA[data_size-2:0], 1'b0}),
        .shift_en (sh_shift_s),
        .shift_in (MEM_SERIAL_OUT),
        .q        (sh_q_s)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        load_mode_d   = 1'b0;
        output_mode_d = 1'b0;
        serial_in_d   = 1'b0;
        cmd_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_err_d     = rsp_err_q;
        rsp_data_d    = rsp_data_q;
        sh_load_s     = 1'b0;
        sh_shift_s    = 1'b0;
`ifdef SERIAL_LINK_CTRL_RUN_EN
        gen_d         = gen_q;
        run_mode_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = {data_size{1'b0}};
                if (CMD_VALID && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    case (op_s)
                        OP_LOAD: begin
                            state_d     = ST_LOAD;
                            cnt_d       = CNT_FULL;
                            load_mode_d = 1'b1;
                            serial_in_d = CMD_DATA[data_size-1];
                            sh_load_s   = 1'b1;
                        end
                        OP_READ: begin
                            state_d       = ST_READ;
                            cnt_d         = CNT_FULL;
                            output_mode_d = 1'b1;
                        end
`ifdef SERIAL_LINK_CTRL_RUN_EN
                        OP_RUN: begin
                            if (CMD_GENS == {gen_width{1'b0}}) begin
                                state_d     = ST_RESP;
                                rsp_valid_d = 1'b1;
                            end else begin
                                state_d    = ST_RUN;
                                gen_d      = CMD_GENS;
                                run_mode_d = 1'b1;
                            end
                        end
`endif
                        default: begin
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                sh_shift_s = 1'b1;
                cnt_d      = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    load_mode_d = 1'b1;
                    serial_in_d = sh_q_s[data_size-1];
                end
            end
            ST_READ: begin
                // Memory output lags the strobe by one edge; skip the first capture.
                sh_shift_s = (cnt_q != CNT_FULL);
                cnt_d      = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_FLUSH;
                end else begin
                    output_mode_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                sh_shift_s  = 1'b1;
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = {sh_q_s[data_size-2:0], MEM_SERIAL_OUT};
            end
`ifdef SERIAL_LINK_CTRL_RUN_EN
            ST_RUN: begin
                gen_d = gen_q - gen_width'(1);
                if (gen_q <= gen_width'(1)) begin
                    gen_d       = {gen_width{1'b0}};
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    run_mode_d = 1'b1;
                end
            end
`endif
            ST_RESP: begin
                if (RSP_READY) begin
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = {data_size{1'b0}};
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = {data_size{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            load_mode_q   <= 1'b0;
            output_mode_q <= 1'b0;
            serial_in_q   <= 1'b0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= {data_size{1'b0}};
`ifdef SERIAL_LINK_CTRL_RUN_EN
            gen_q         <= {gen_width{1'b0}};
            run_mode_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            load_mode_q   <= load_mode_d;
            output_mode_q <= output_mode_d;
            serial_in_q   <= serial_in_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_data_q    <= rsp_data_d;
`ifdef SERIAL_LINK_CTRL_RUN_EN
            gen_q         <= gen_d;
            run_mode_q    <= run_mode_d;
`endif
        end
    end

    assign CMD_READY   = cmd_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_DATA    = rsp_data_q;
    assign LOAD_MODE   = load_mode_q;
    assign OUTPUT_MODE = output_mode_q;
    assign SERIAL_IN   = serial_in_q;
`ifdef SERIAL_LINK_CTRL_RUN_EN
    assign RUN_MODE    = run_mode_q;
`else
    assign RUN_MODE      = 1'b0;
    assign unused_gens_s = ^CMD_GENS;
`endif

endmodule

// File: tb/tb_serial_link_ctrl.sv
// Self-checking bench for serial_link_ctrl with a behavioural serial memory model.
module tb_serial_link_ctrl;

    localparam int DS = 64;
    localparam int GW = 16;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic [1:0]    CMD_OP = 2'b00;
    logic [DS-1:0] CMD_DATA = '0;
    logic [GW-1:0] CMD_GENS = '0;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b1;
    logic [DS-1:0] RSP_DATA;
    logic          RSP_ERR;
    logic          LOAD_MODE, OUTPUT_MODE, RUN_MODE, SERIAL_IN;
    logic          MEM_SERIAL_OUT;

    serial_link_ctrl #(.data_size(DS), .gen_width(GW)) dut (
        .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .CMD_GENS(CMD_GENS),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .LOAD_MODE(LOAD_MODE), .OUTPUT_MODE(OUTPUT_MODE), .RUN_MODE(RUN_MODE),
        .SERIAL_IN(SERIAL_IN), .MEM_SERIAL_OUT(MEM_SERIAL_OUT)
    );

    always #5 CLK = ~CLK;

    // Serial memory: shifts in on load, rotates with a registered output on readout.
    logic [DS-1:0] mem = '0;
    logic          mem_out = 1'b0;
    always @(posedge CLK) begin
        if (LOAD_MODE) begin
            mem <= {mem[DS-2:0], SERIAL_IN};
        end else if (OUTPUT_MODE) begin
            mem     <= {mem[DS-2:0], mem[DS-1]};
            mem_out <= mem[DS-1];
        end
    end
    assign MEM_SERIAL_OUT = mem_out;

    int errors = 0;
    int checks = 0;
    logic [DS-1:0] ref_mem = '0;

    int            o_lat, o_nload, o_nout, o_nrun;
    logic [DS-1:0] o_sbits;
    bit            o_multi, o_busy_rdy;

    // Reference rules for one command.
    function automatic int exp_lat(logic [1:0] op, logic [GW-1:0] g);
        case (op)
            2'b00: return DS + 1;
            2'b01: return DS + 2;
            2'b10: begin
`ifdef SERIAL_LINK_CTRL_RUN_EN
                return (g == '0) ? 1 : int'(g) + 1;
`else
                return 1;
`endif
            end
            default: return 1;
        endcase
    endfunction

    function automatic bit exp_err(logic [1:0] op);
`ifdef SERIAL_LINK_CTRL_RUN_EN
        return op == 2'b11;
`else
        return op[1];
`endif
    endfunction

    function automatic int exp_nrun(logic [1:0] op, logic [GW-1:0] g);
`ifdef SERIAL_LINK_CTRL_RUN_EN
        return (op == 2'b10) ? int'(g) : 0;
`else
        return 0;
`endif
    endfunction

    task automatic issue(input logic [1:0] op, input logic [DS-1:0] data, input logic [GW-1:0] g);
        int w;
        w = 0;
        CMD_OP = op; CMD_DATA = data; CMD_GENS = g; CMD_VALID = 1'b1;
        while (CMD_READY !== 1'b1 && w < 300) begin
            @(posedge CLK); #1; w++;
        end
        checks++;
        if (w >= 300) begin
            errors++;
            $display("FAIL issue_timeout: CMD_READY=%b after %0d cycles, required 1", CMD_READY, w);
        end
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
    endtask

    // Watches cycles T+1.. until RSP_VALID; leaves the bench in the response cycle.
    task automatic observe();
        o_lat = 0; o_nload = 0; o_nout = 0; o_nrun = 0; o_sbits = '0;
        o_multi = 1'b0; o_busy_rdy = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (int'(LOAD_MODE) + int'(OUTPUT_MODE) + int'(RUN_MODE) > 1) o_multi = 1'b1;
            if (CMD_READY !== 1'b0) o_busy_rdy = 1'b1;
            if (RSP_VALID === 1'b1) begin
                o_lat = k;
                break;
            end
            if (LOAD_MODE === 1'b1) begin
                o_nload++;
                o_sbits = {o_sbits[DS-2:0], SERIAL_IN};
            end
            if (OUTPUT_MODE === 1'b1) o_nout++;
            if (RUN_MODE === 1'b1) o_nrun++;
            @(posedge CLK); #1;
        end
        checks++;
        if (o_lat == 0) begin
            errors++;
            $display("FAIL observe_timeout: RSP_VALID not seen within 400 cycles, required a response");
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        checks++;
        if ({LOAD_MODE, OUTPUT_MODE, RUN_MODE, SERIAL_IN, RSP_VALID, RSP_ERR} !== 6'b0 || RSP_DATA !== '0) begin
            errors++;
            $display("FAIL reset_outputs: strobes/rsp=%b data=%h, required all 0",
                     {LOAD_MODE, OUTPUT_MODE, RUN_MODE, SERIAL_IN, RSP_VALID, RSP_ERR}, RSP_DATA);
        end
        checks++;
        if (CMD_READY !== 1'b1) begin
            errors++; $display("FAIL reset_ready: CMD_READY=%b, required 1", CMD_READY);
        end
    endtask

    task automatic test_load();
        logic [DS-1:0] d;
        d = 64'hDEADBEEF_0123ABCD;
        issue(2'b00, d, '0);
        observe();
        ref_mem = d;
        checks++;
        if (o_nload != DS) begin errors++; $display("FAIL load_cycles: got %0d, required %0d", o_nload, DS); end
        checks++;
        if (o_sbits !== d) begin errors++; $display("FAIL load_serial: got %h, required %h", o_sbits, d); end
        checks++;
        if (o_lat != DS + 1) begin errors++; $display("FAIL load_latency: got %0d, required %0d", o_lat, DS + 1); end
        checks++;
        if (RSP_ERR !== 1'b0 || RSP_DATA !== '0) begin
            errors++; $display("FAIL load_rsp: err=%b data=%h, required 0/0", RSP_ERR, RSP_DATA);
        end
        checks++;
        if (mem !== d) begin errors++; $display("FAIL load_mem: got %h, required %h", mem, d); end
        @(posedge CLK); #1;
        checks++;
        if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
            errors++; $display("FAIL load_release: valid=%b ready=%b, required 0/1", RSP_VALID, CMD_READY);
        end
    endtask

    task automatic test_round_trip();
        logic [DS-1:0] d;
        d = 64'h8000_0000_0000_0001;
        issue(2'b00, d, '0);
        observe();
        ref_mem = d;
        @(posedge CLK); #1;
        for (int r = 0; r < 2; r++) begin
            issue(2'b01, '0, '0);
            observe();
            checks++;
            if (RSP_DATA !== d || RSP_ERR !== 1'b0) begin
                errors++; $display("FAIL read_data[%0d]: got %h err=%b, required %h", r, RSP_DATA, RSP_ERR, d);
            end
            checks++;
            if (o_nout != DS || o_lat != DS + 2) begin
                errors++; $display("FAIL read_timing[%0d]: strobes=%0d lat=%0d, required %0d/%0d", r, o_nout, o_lat, DS, DS + 2);
            end
            checks++;
            if (mem !== d) begin errors++; $display("FAIL read_mem_intact[%0d]: got %h, required %h", r, mem, d); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_run();
`ifdef SERIAL_LINK_CTRL_RUN_EN
        issue(2'b10, '0, 16'd5);
        observe();
        checks++;
        if (o_nrun != 5 || o_lat != 6 || RSP_ERR !== 1'b0) begin
            errors++; $display("FAIL run5: runs=%0d lat=%0d err=%b, required 5/6/0", o_nrun, o_lat, RSP_ERR);
        end
        @(posedge CLK); #1;
        issue(2'b10, '0, 16'd0);
        observe();
        checks++;
        if (o_nrun != 0 || o_lat != 1 || RSP_ERR !== 1'b0) begin
            errors++; $display("FAIL run0: runs=%0d lat=%0d err=%b, required 0/1/0", o_nrun, o_lat, RSP_ERR);
        end
`else
        issue(2'b10, '0, 16'd5);
        observe();
        checks++;
        if (o_nrun != 0 || o_lat != 1 || RSP_ERR !== 1'b1) begin
            errors++; $display("FAIL run_disabled: runs=%0d lat=%0d err=%b, required 0/1/1", o_nrun, o_lat, RSP_ERR);
        end
`endif
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure();
        bit bad;
        bad = 1'b0;
        RSP_READY = 1'b0;
        issue(2'b01, '0, '0);
        observe();
        CMD_OP = 2'b11; CMD_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (RSP_VALID !== 1'b1 || RSP_DATA !== ref_mem || CMD_READY !== 1'b0) bad = 1'b1;
            @(posedge CLK); #1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL backpressure_hold: valid=%b data=%h ready=%b, required 1/%h/0", RSP_VALID, RSP_DATA, CMD_READY, ref_mem);
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (CMD_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
            errors++; $display("FAIL backpressure_release: ready=%b valid=%b, required 1/0", CMD_READY, RSP_VALID);
        end
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        observe();
        checks++;
        if (RSP_ERR !== 1'b1 || o_lat != 1 || o_nload + o_nout + o_nrun != 0 || RSP_DATA !== '0) begin
            errors++; $display("FAIL illegal_op: err=%b lat=%0d strobes=%0d data=%h, required 1/1/0/0",
                               RSP_ERR, o_lat, o_nload + o_nout + o_nrun, RSP_DATA);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        logic [DS-1:0] d;
        bit seen;
        seen = 1'b0;
        issue(2'b00, {$urandom, $urandom}, '0);
        repeat (29) begin @(posedge CLK); #1; end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        checks++;
        if (LOAD_MODE !== 1'b0 || RSP_VALID !== 1'b0 || SERIAL_IN !== 1'b0 || CMD_READY !== 1'b1) begin
            errors++; $display("FAIL reset_mid: load=%b valid=%b sin=%b ready=%b, required 0/0/0/1",
                               LOAD_MODE, RSP_VALID, SERIAL_IN, CMD_READY);
        end
        for (int i = 0; i < 80; i++) begin
            if (RSP_VALID !== 1'b0 || LOAD_MODE !== 1'b0) seen = 1'b1;
            @(posedge CLK); #1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL reset_mid_quiet: activity after abort, required none"); end
        d = {$urandom, $urandom};
        issue(2'b00, d, '0);
        observe();
        ref_mem = d;
        @(posedge CLK); #1;
        issue(2'b01, '0, '0);
        observe();
        checks++;
        if (RSP_DATA !== d) begin errors++; $display("FAIL reset_mid_roundtrip: got %h, required %h", RSP_DATA, d); end
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        logic [1:0]    op;
        logic [DS-1:0] d;
        logic [GW-1:0] g;
        int            dly;
        for (int n = 0; n < 24; n++) begin
            op  = 2'($urandom_range(0, 3));
            d   = {$urandom, $urandom};
            g   = GW'($urandom_range(0, 12));
            dly = $urandom_range(0, 3);
            RSP_READY = (dly == 0);
            issue(op, d, g);
            observe();
            if (op == 2'b00) ref_mem = d;
            checks++;
            if (o_lat != exp_lat(op, g)) begin
                errors++; $display("FAIL rnd_lat[%0d] op=%0d: got %0d, required %0d", n, op, o_lat, exp_lat(op, g));
            end
            checks++;
            if (o_nload != ((op == 2'b00) ? DS : 0) || o_nout != ((op == 2'b01) ? DS : 0) || o_nrun != exp_nrun(op, g)) begin
                errors++; $display("FAIL rnd_strobes[%0d] op=%0d: load=%0d out=%0d run=%0d", n, op, o_nload, o_nout, o_nrun);
            end
            checks++;
            if (o_multi || o_busy_rdy) begin
                errors++; $display("FAIL rnd_exclusive[%0d]: multi=%b busy_ready=%b, required 0/0", n, o_multi, o_busy_rdy);
            end
            checks++;
            if (RSP_ERR !== exp_err(op) || RSP_DATA !== ((op == 2'b01) ? ref_mem : '0)) begin
                errors++; $display("FAIL rnd_rsp[%0d] op=%0d: err=%b data=%h, required %b/%h", n, op, RSP_ERR, RSP_DATA,
                                   exp_err(op), (op == 2'b01) ? ref_mem : '0);
            end
            checks++;
            if (mem !== ref_mem || (op == 2'b00 && o_sbits !== d)) begin
                errors++; $display("FAIL rnd_mem[%0d]: got %h, required %h", n, mem, ref_mem);
            end
            repeat (dly) begin @(posedge CLK); #1; end
            RSP_READY = 1'b1;
            @(posedge CLK); #1;
            checks++;
            if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1) begin
                errors++; $display("FAIL rnd_release[%0d]: valid=%b ready=%b, required 0/1", n, RSP_VALID, CMD_READY);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_round_trip();
        test_run();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
